// File: rtl/mem_responder_pkg.sv
// Shared types for the data-cache memory responder: byte/word types, FSM states.
// Word layout: element [0] is the lowest byte address of the word.
package mem_responder_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned CNT_BITS   = 8;

  typedef logic [7:0]            byte_t;
  typedef byte_t [0:WORD_BYTES-1] word_t;
  typedef logic [WORD_BYTES-1:0] mask_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } mem_state_t;

endpackage

// File: rtl/mem_responder_if.sv
// Cache-to-memory request/response bundle. mem_byte_en exists only when
// MEM_BYTE_MASK_EN is defined.
interface mem_responder_if;
  import mem_responder_pkg::*;

  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_write_en;
  word_t       mem_data_in;
`ifdef MEM_BYTE_MASK_EN
  mask_t       mem_byte_en;
`endif
  word_t       mem_data_out;
  logic        mem_busy;
  logic        mem_done;

  modport master (
    output mem_req,
    output mem_addr,
    output mem_write_en,
    output mem_data_in,
`ifdef MEM_BYTE_MASK_EN
    output mem_byte_en,
`endif
    input  mem_data_out,
    input  mem_busy,
    input  mem_done
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    input  mem_write_en,
    input  mem_data_in,
`ifdef MEM_BYTE_MASK_EN
    input  mem_byte_en,
`endif
    output mem_data_out,
    output mem_busy,
    output mem_done
  );

endinterface

// File: rtl/mem_responder_storage.sv
// Word-organised byte storage with one synchronous read/write port and per-byte write mask.
// The read register holds its value until the next read; contents are never reset.
module mem_responder_storage
  import mem_responder_pkg::*;
#(
  parameter int unsigned WORD_ADDR_BITS = 14
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic                      we,
  input  logic [WORD_ADDR_BITS-1:0] addr,
  input  word_t                     wdata,
  input  mask_t                     wmask,
  output word_t                     rdata
);

  localparam int unsigned Depth = 2 ** WORD_ADDR_BITS;

  word_t mem_q [Depth];
  word_t rdata_q;

  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int i = 0; i < int'(WORD_BYTES); i++) begin
        if (wmask[i]) begin
          mem_q[addr][i] <= wdata[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (en && !we) begin
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Main-memory responder: accepts one word request at a time and completes it after LATENCY cycles
// with a one-cycle mem_done pulse. Define MEM_BYTE_MASK_EN to enable per-byte write masking.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 16,
  parameter int unsigned LATENCY   = 4
) (
  input logic           clk,
  input logic           reset,
  mem_responder_if.slave bus
);

  localparam int unsigned WordAddrBits = ADDR_BITS - 2;
  localparam logic [CNT_BITS-1:0] CntInit =
    (LATENCY > 1) ? CNT_BITS'(LATENCY - 2) : '0;

  mem_state_t              state_q, state_d;
  logic [CNT_BITS-1:0]     cnt_q, cnt_d;
  logic [WordAddrBits-1:0] addr_q;
  logic                    we_q;
  word_t                   data_q;
  mask_t                   mask_q;

  logic                    accept;
  logic                    access_en;
  mask_t                   req_mask;
  logic [WordAddrBits-1:0] acc_addr;
  logic                    acc_we;
  word_t                   acc_data;
  mask_t                   acc_mask;
  word_t                   rdata;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.mem_addr[31:ADDR_BITS], bus.mem_addr[1:0]};

`ifdef MEM_BYTE_MASK_EN
  assign req_mask = bus.mem_byte_en;
`else
  assign req_mask = '1;
`endif

  assign accept = (state_q == IDLE) && bus.mem_req;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && accept) begin
      addr_q <= bus.mem_addr[ADDR_BITS-1:2];
      we_q   <= bus.mem_write_en;
      data_q <= bus.mem_data_in;
      mask_q <= req_mask;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.mem_req) begin
          if (LATENCY == 1) begin
            state_d = DONE;
          end else begin
            state_d = BUSY;
            cnt_d   = CntInit;
          end
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The access happens on the edge entering DONE; with LATENCY==1 that is the accepting edge,
  // so the live request fields are used because the latches are not loaded yet.
  always_comb begin
    bus.mem_busy = (state_q != IDLE);
    bus.mem_done = (state_q == DONE);
    access_en    = !reset && (state_d == DONE) && (state_q != DONE);
    if (state_q == IDLE) begin
      acc_addr = bus.mem_addr[ADDR_BITS-1:2];
      acc_we   = bus.mem_write_en;
      acc_data = bus.mem_data_in;
      acc_mask = req_mask;
    end else begin
      acc_addr = addr_q;
      acc_we   = we_q;
      acc_data = data_q;
      acc_mask = mask_q;
    end
  end

  mem_responder_storage #(
    .WORD_ADDR_BITS(WordAddrBits)
  ) u_storage (
    .clk   (clk),
    .reset (reset),
    .en    (access_en),
    .we    (acc_we),
    .addr  (acc_addr),
    .wdata (acc_data),
    .wmask (acc_mask),
    .rdata (rdata)
  );

  assign bus.mem_data_out = rdata;

endmodule
